score_player: RTL and testbench

Auto-play note sequencer for the piano. It steps through a small writable score memory, with each entry holding a note code and a duration in beats. Timing comes from the one-cycle beat strobe produced by the 50 MHz-to-2 Hz enable divider, so this block is the consumer end of that strobe. Its note code output drives the tone generator in place of the keyboard whenever auto-play is active.

---
 rtl/score_player.sv | 149 ++++++++++++++
 tb/tb_score_player.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_player.sv
// Auto-play note sequencer: walks a writable score of {note, dur} entries,
// holding each note for dur beat strobes and driving the tone generator's note code.
module score_player #(
    parameter int SONG_LEN = 32,
    parameter int NOTE_W   = 5,
    parameter int DUR_W    = 3,
    localparam int AW      = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1,
    localparam int EW      = NOTE_W + DUR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_en,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [EW-1:0]     wr_data,
    output logic [NOTE_W-1:0] note_out,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_FINISH
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(SONG_LEN - 1);

    state_t              state_q, state_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [AW-1:0]       step_q, step_d;
    logic [DUR_W-1:0]    remain_q, remain_d;
    logic [EW-1:0]       mem_q [SONG_LEN];

    logic [EW-1:0]       rd_entry;
    logic [NOTE_W-1:0]   rd_note;
    logic [DUR_W-1:0]    rd_dur;
    logic                wr_ok;
    logic                end_loop;

    assign rd_entry = mem_q[step_q];
    assign rd_note  = rd_entry[EW-1:DUR_W];
    assign rd_dur   = rd_entry[DUR_W-1:0];

    // The score is frozen while playing; stop also masks a coincident write.
    assign wr_ok    = wr_en && !stop && (state_q == S_IDLE);

    // Looping back to entry 0 is only meaningful if we are not already there,
    // otherwise an empty score with loop_en would spin in LOAD forever.
    assign end_loop = loop_en && (step_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SONG_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            note_q   <= '0;
            step_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            step_q   <= step_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        step_d   = step_q;
        remain_d = remain_q;

        unique case (state_q)
            S_IDLE: begin
                note_d = '0;
                if (start) begin
                    step_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (rd_dur != '0) begin
                    note_d   = rd_note;
                    remain_d = rd_dur;
                    state_d  = S_HOLD;
                end else if (end_loop) begin
                    step_d = '0;
                end else begin
                    note_d  = '0;
                    state_d = S_FINISH;
                end
            end
            S_HOLD: begin
                if (tick_en) begin
                    remain_d = remain_q - DUR_W'(1);
                    if (remain_q == DUR_W'(1)) begin
                        // Running off the last entry behaves like hitting an end marker.
                        if (step_q == LAST_IDX) begin
                            if (end_loop) begin
                                step_d  = '0;
                                state_d = S_LOAD;
                            end else begin
                                note_d  = '0;
                                state_d = S_FINISH;
                            end
                        end else begin
                            step_d  = step_q + AW'(1);
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_FINISH: begin
                note_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                note_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d = S_IDLE;
            note_d  = '0;
            step_d  = '0;
        end
    end

    assign note_out = note_q;
    assign step_idx = step_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FINISH);

endmodule

// File: tb/tb_score_player.sv
// Directed bench for score_player: a cycle-by-cycle vector table for the basic
// song, plus hand-written sequences for stop, loop, busy writes, reset and a full score.
module tb_score_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_en, start, stop, loop_en, wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] note_out;
    logic       busy, done;
    logic [4:0] step_idx;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    score_player #(.SONG_LEN(32), .NOTE_W(5), .DUR_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_en  (tick_en),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .note_out (note_out),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    typedef struct {
        logic       start;
        logic       stop;
        logic       tick;
        logic [4:0] exp_note;
        logic       exp_busy;
        logic       exp_done;
        logic [4:0] exp_step;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic s, input logic p, input logic t,
                                input int n, input logic b, input logic d, input int st);
        vec_t v;
        v.start = s; v.stop = p; v.tick = t;
        v.exp_note = 5'(n); v.exp_busy = b; v.exp_done = d; v.exp_step = 5'(st);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int note, input int dur);
        wr_en = 1'b1; wr_addr = 5'(addr); wr_data = {5'(note), 3'(dur)};
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    // One beat followed by enough cycles for LOAD -> HOLD (or FINISH -> IDLE).
    task automatic beat();
        tick_en = 1'b1; cyc(); tick_en = 1'b0;
        cyc(); cyc();
    endtask

    task automatic write_song();
        wr(0, 1, 2); wr(1, 3, 1); wr(2, 0, 1); wr(3, 5, 3); wr(4, 0, 0);
    endtask

    initial begin
        int d0;
        logic [4:0] samp[7];
        int exp_samp[7] = '{1, 1, 3, 0, 5, 5, 5};

        rst_n = 1'b0; tick_en = 0; start = 0; stop = 0; loop_en = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        #12;
        chk("reset note", note_out, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset step", step_idx, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        write_song();
        chk("idle after writes", busy, 0);

        // Dense-tick playback of the basic song, one row per clock edge.
        vecs[0]  = mk(1, 0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 1, 0, 1);
        vecs[4]  = mk(0, 0, 0, 3, 1, 0, 1);
        vecs[5]  = mk(0, 0, 1, 3, 1, 0, 2);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0, 2);
        vecs[7]  = mk(0, 0, 1, 0, 1, 0, 3);
        vecs[8]  = mk(0, 0, 0, 5, 1, 0, 3);
        vecs[9]  = mk(0, 0, 1, 5, 1, 0, 3);
        vecs[10] = mk(1, 0, 0, 5, 1, 0, 3);
        vecs[11] = mk(0, 0, 1, 5, 1, 0, 3);
        vecs[12] = mk(0, 0, 1, 5, 1, 0, 4);
        vecs[13] = mk(0, 0, 0, 0, 1, 1, 4);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 4);
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; tick_en = vecs[i].tick;
            cyc();
            start = 0; stop = 0; tick_en = 0;
            $display("vec %0d: note=%0d busy=%0d done=%0d step=%0d", i, note_out, busy, done, step_idx);
            chk($sformatf("vec%0d note", i), note_out, vecs[i].exp_note);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d done", i), done, vecs[i].exp_done);
            chk($sformatf("vec%0d step", i), step_idx, vecs[i].exp_step);
        end

        // Same song with a beat every 10 cycles; sample the note just before each beat.
        d0 = done_cnt;
        pulse_start();
        for (int k = 0; k < 7; k++) begin
            repeat (9) cyc();
            samp[k] = note_out;
            tick_en = 1'b1; cyc(); tick_en = 1'b0;
        end
        repeat (4) cyc();
        for (int k = 0; k < 7; k++) chk($sformatf("slow beat%0d note", k), samp[k], exp_samp[k]);
        chk("slow done count", done_cnt - d0, 1);
        chk("slow end busy", busy, 0);
        chk("slow end note", note_out, 0);
        $display("slow playback: done pulses=%0d", done_cnt - d0);

        // Write and start while busy are both ignored.
        pulse_start(); cyc();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = {5'd9, 3'd7}; start = 1'b1;
        cyc();
        wr_en = 1'b0; start = 1'b0;
        chk("busy write note", note_out, 1);
        chk("busy write step", step_idx, 0);
        for (int k = 0; k < 7; k++) beat();
        chk("busy write song end", busy, 0);
        pulse_start(); cyc();
        chk("replay after busy write", note_out, 1);
        pulse_stop();
        $display("busy write: replay note=%0d", note_out);

        // Stop coincident with a beat during the second note.
        d0 = done_cnt;
        pulse_start(); cyc();
        beat(); beat();
        chk("second note", note_out, 3);
        chk("second note step", step_idx, 1);
        stop = 1'b1; tick_en = 1'b1; cyc(); stop = 1'b0; tick_en = 1'b0;
        chk("stop busy", busy, 0);
        chk("stop note", note_out, 0);
        chk("stop step", step_idx, 0);
        cyc(); cyc();
        chk("stop no done", done_cnt - d0, 0);
        pulse_start(); cyc();
        chk("restart note", note_out, 1);
        chk("restart step", step_idx, 0);
        pulse_stop();
        $display("stop+tick: busy=%0d note=%0d", busy, note_out);

        // Loop back to entry 0 after the end marker.
        d0 = done_cnt;
        loop_en = 1'b1;
        pulse_start(); cyc();
        for (int k = 0; k < 7; k++) beat();
        cyc();
        chk("loop note", note_out, 1);
        chk("loop step", step_idx, 0);
        chk("loop busy", busy, 1);
        chk("loop no done", done_cnt - d0, 0);
        loop_en = 1'b0;
        pulse_stop();
        $display("loop: note=%0d step=%0d", note_out, step_idx);

        // Asynchronous reset mid-note, then play the cleared (empty) score.
        pulse_start(); cyc();
        chk("pre-reset note", note_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset note", note_out, 0);
        chk("async reset busy", busy, 0);
        chk("async reset step", step_idx, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        d0 = done_cnt;
        pulse_start();
        chk("empty load busy", busy, 1);
        chk("empty load done", done, 0);
        cyc();
        chk("empty finish done", done, 1);
        chk("empty finish note", note_out, 0);
        cyc();
        chk("empty idle busy", busy, 0);
        chk("empty idle done", done, 0);
        chk("empty done count", done_cnt - d0, 1);
        $display("empty score: done pulses=%0d", done_cnt - d0);

        // Full 32-entry score, dur=1 each, must stop at entry 31 without wrapping.
        for (int i = 0; i < 32; i++) wr(i, (i % 31) + 1, 1);
        d0 = done_cnt;
        pulse_start(); cyc();
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("full step%0d", k), step_idx, k);
            chk($sformatf("full note%0d", k), note_out, (k % 31) + 1);
            tick_en = 1'b1; cyc(); tick_en = 1'b0;
            if (k < 31) cyc();
        end
        chk("full finish done", done, 1);
        chk("full finish step", step_idx, 31);
        cyc();
        chk("full idle busy", busy, 0);
        chk("full done count", done_cnt - d0, 1);
        $display("full score: final step=%0d", step_idx);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
